// File: rtl/omem_pkg.sv
// Shared definitions for the output membrane-potential memory node:
// packet layout, opcodes, node addresses and controller states.
package omem_pkg;

  localparam int PKT_BITS  = 33;
  localparam int DATA_BITS = 25;
  localparam int ADDR_HI   = 32;
  localparam int ADDR_LO   = 29;
  localparam int OP_HI     = 28;
  localparam int OP_LO     = 25;
  localparam int DATA_HI   = 24;

  localparam logic [3:0] OP_PARTIAL_SUM         = 4'd0;
  localparam logic       OP_READ_POT            = 1'b1;
  localparam logic [3:0] OP_TS_DONE_CTRL        = 4'd1;
  localparam logic [3:0] OP_FIRST_TIMESTEP_DONE = 4'd15;

  localparam int NODE_CTRL     = 0;
  localparam int NODE_SPE_BASE = 9;
  localparam int NODE_OMEM     = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_NOTIFY,
    S_BCAST
  } omem_state_e;

  function automatic logic [PKT_BITS-1:0] mk_pkt(
    input logic [3:0]           addr,
    input logic [3:0]           op,
    input logic [DATA_BITS-1:0] data
  );
    return {addr, op, data};
  endfunction

endpackage

// File: rtl/omem_bank.sv
// Potential/spike storage: one write port, one async read port,
// and an independent spike-only read port. Contents are not reset.
module omem_bank
  import omem_pkg::*;
#(
  parameter int DEPTH = 441,
  parameter int W     = 14,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic [AW-1:0] spk_addr,
  output logic          spk_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata    = mem_q[raddr];
  assign spk_data = mem_q[spk_addr][0];

endmodule

// File: rtl/omem_potential_store.sv
// NoC node holding output-neuron potentials: serves SPE reads,
// stores writes and signals timestep completion.
module omem_potential_store
  import omem_pkg::*;
#(
  parameter int PKT_W         = PKT_BITS,
  parameter int POT_W         = 13,
  parameter int NUM_SPE       = 3,
  parameter int SLOTS_PER_SPE = 147,
  parameter int OMEM_ID       = NODE_OMEM,
  parameter int SPE_ADDR_BASE = NODE_SPE_BASE,
  parameter int CTRL_ID       = NODE_CTRL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  input  logic [8:0]       spk_rd_addr,
  output logic             spk_rd_data,
  output logic [7:0]       timestep,
  output logic             err
);

  localparam int PTR_W = $clog2(SLOTS_PER_SPE + 1);
  localparam int IDX_W = (NUM_SPE > 1) ? $clog2(NUM_SPE) : 1;
  localparam int DEPTH = NUM_SPE * SLOTS_PER_SPE;
  localparam int AW    = 9;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(SLOTS_PER_SPE);

  omem_state_e state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [PKT_W-1:0] out_data_q, out_data_d;
  logic [7:0] ts_q, ts_d;
  logic err_q, err_d;
  logic first_q, first_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q [NUM_SPE];
  logic [PTR_W-1:0] ptr_d [NUM_SPE];

  logic [3:0] pkt_addr;
  logic [2:0] pe_id;
  logic kind;
  logic accept;
  logic pe_ok;
  logic bad;
  logic all_full;
  logic we;
  logic [PTR_W-1:0] cur_ptr;
  logic [PTR_W-1:0] nxt;
  logic [AW-1:0] bank_addr;
  logic [POT_W:0] rd_word;
  logic [POT_W-1:0] rd_pot;
  logic unused_bits;

  assign pkt_addr = in_data[ADDR_HI:ADDR_LO];
  assign pe_id    = in_data[OP_HI:OP_LO+1];
  assign kind     = in_data[OP_LO];
  assign accept   = in_valid && in_ready_q;

  assign unused_bits = ^{in_data[DATA_HI:POT_W+1], rd_word[0]};

  always_comb begin
    pe_ok    = (int'(pe_id) < NUM_SPE);
    cur_ptr  = '0;
    all_full = 1'b1;
    nxt      = '0;
    for (int k = 0; k < NUM_SPE; k++) begin
      if (pe_id == 3'(k)) cur_ptr = ptr_q[k];
    end
    for (int k = 0; k < NUM_SPE; k++) begin
      nxt = ptr_q[k];
      if (pe_id == 3'(k)) nxt = ptr_q[k] + PTR_W'(1);
      if (nxt != FULL) all_full = 1'b0;
    end
  end

  assign bank_addr = AW'(pe_id) * AW'(SLOTS_PER_SPE) + AW'(cur_ptr);
  assign rd_pot    = (ts_q == 8'd0) ? '0 : rd_word[POT_W:1];

  assign bad = (pkt_addr != 4'(OMEM_ID)) || !pe_ok ||
               ((kind != OP_READ_POT) && (cur_ptr == FULL));

  assign we = accept && !bad && (kind != OP_READ_POT);

  omem_bank #(
    .DEPTH (DEPTH),
    .W     (POT_W + 1),
    .AW    (AW)
  ) u_bank (
    .clk      (clk),
    .we       (we),
    .waddr    (bank_addr),
    .wdata    (in_data[POT_W:0]),
    .raddr    (bank_addr),
    .rdata    (rd_word),
    .spk_addr (spk_rd_addr),
    .spk_data (spk_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ts_d        = ts_q;
    err_d       = err_q;
    first_d     = first_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (accept && bad) begin
          err_d = 1'b1;
        end else if (accept && kind == OP_READ_POT) begin
          state_d     = S_RESP;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = PKT_W'(mk_pkt(
            4'(SPE_ADDR_BASE) + 4'(pe_id),
            OP_PARTIAL_SUM,
            DATA_BITS'(rd_pot)));
        end else if (accept) begin
          for (int k = 0; k < NUM_SPE; k++) begin
            if (pe_id == 3'(k)) ptr_d[k] = cur_ptr + PTR_W'(1);
          end
          if (all_full) begin
            for (int k = 0; k < NUM_SPE; k++) ptr_d[k] = '0;
            ts_d        = ts_q + 8'd1;
            first_d     = (ts_q == 8'd0);
            state_d     = S_NOTIFY;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = PKT_W'(mk_pkt(
              4'(CTRL_ID), OP_TS_DONE_CTRL, DATA_BITS'(ts_q + 8'd1)));
          end
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      S_NOTIFY: begin
        if (out_ready && first_q) begin
          state_d    = S_BCAST;
          idx_d      = '0;
          out_data_d = PKT_W'(mk_pkt(
            4'(SPE_ADDR_BASE), OP_FIRST_TIMESTEP_DONE, '0));
        end else if (out_ready) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      S_BCAST: begin
        if (out_ready && idx_q == IDX_W'(NUM_SPE - 1)) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end else if (out_ready) begin
          idx_d      = idx_q + IDX_W'(1);
          out_data_d = PKT_W'(mk_pkt(
            4'(SPE_ADDR_BASE) + 4'(idx_q + IDX_W'(1)),
            OP_FIRST_TIMESTEP_DONE, '0));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ts_q        <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      idx_q       <= '0;
      for (int k = 0; k < NUM_SPE; k++) ptr_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ts_q        <= ts_d;
      err_q       <= err_d;
      first_q     <= first_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign timestep  = ts_q;
  assign err       = err_q;

endmodule
